// File: rtl/girl10_out_mon.sv
// Output monitor for the upstream FSM's 9-bit y vector: registers and classifies each sample,
// counts legal events while running and latches an alarm on illegal codes or prolonged silence.
module girl10_out_mon #(
    parameter int unsigned SILENT_MAX = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [8:0]       y_in,
    output logic [8:0]       y_q,
    output logic [3:0]       code_id,
    output logic             illegal,
    output logic             alarm,
    output logic [CNT_W-1:0] evt_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StAlarm = 2'd2
    } state_e;

    localparam logic [7:0] SilentMaxW = 8'(SILENT_MAX);
    localparam logic [3:0] CodeIllegal = 4'hF;

    state_e           state_q, state_d;
    logic [7:0]       sil_q, sil_d;
    logic [CNT_W-1:0] evt_q, evt_d;
    logic             ill_q, ill_d;
    logic [8:0]       yq_q;
    logic [3:0]       code_q, code_c;

    always_comb begin
        code_c = CodeIllegal;
        case (y_in)
            9'h000:  code_c = 4'd0;
            9'h0C0:  code_c = 4'd1;
            9'h010:  code_c = 4'd2;
            9'h114:  code_c = 4'd3;
            9'h003:  code_c = 4'd4;
            9'h00C:  code_c = 4'd5;
            9'h008:  code_c = 4'd6;
            9'h005:  code_c = 4'd7;
            9'h030:  code_c = 4'd8;
            default: code_c = CodeIllegal;
        endcase
    end

    // Alarm conditions are evaluated before the en-driven return to idle so they win.
    always_comb begin
        state_d = state_q;
        sil_d   = sil_q;
        evt_d   = evt_q;
        ill_d   = 1'b0;
        if (clr) begin
            state_d = StIdle;
            sil_d   = '0;
            evt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (en) state_d = StRun;
                end
                StRun: begin
                    if (code_c == CodeIllegal) begin
                        ill_d   = 1'b1;
                        sil_d   = '0;
                        state_d = StAlarm;
                    end else if (code_c == 4'd0) begin
                        sil_d = sil_q + 8'd1;
                        if (sil_d == SilentMaxW) begin
                            state_d = StAlarm;
                        end else if (!en) begin
                            state_d = StIdle;
                        end
                    end else begin
                        sil_d = '0;
                        if (evt_q != {CNT_W{1'b1}}) evt_d = evt_q + CNT_W'(1);
                        if (!en) state_d = StIdle;
                    end
                end
                StAlarm: begin
                    state_d = StAlarm;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            sil_q   <= '0;
            evt_q   <= '0;
            ill_q   <= 1'b0;
            yq_q    <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            sil_q   <= sil_d;
            evt_q   <= evt_d;
            ill_q   <= ill_d;
            yq_q    <= y_in;
            code_q  <= code_c;
        end
    end

    assign y_q     = yq_q;
    assign code_id = code_q;
    assign illegal = ill_q;
    assign alarm   = (state_q == StAlarm);
    assign evt_cnt = evt_q;
    assign state   = state_q;

endmodule

// File: tb/tb_girl10_out_mon.sv
// Scoreboard bench for girl10_out_mon: a behavioural model pushes the expected outputs for each
// driven sample, and they are popped and compared one cycle later.
module tb_girl10_out_mon;

    localparam int unsigned SMAX = 8;
    localparam int unsigned CW   = 4;

    logic          clk = 1'b0;
    logic          rst, en, clr;
    logic [8:0]    y_in;
    logic [8:0]    y_q;
    logic [3:0]    code_id;
    logic          illegal, alarm;
    logic [CW-1:0] evt_cnt;
    logic [1:0]    state;

    girl10_out_mon #(
        .SILENT_MAX(SMAX),
        .CNT_W     (CW)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .clr    (clr),
        .y_in   (y_in),
        .y_q    (y_q),
        .code_id(code_id),
        .illegal(illegal),
        .alarm  (alarm),
        .evt_cnt(evt_cnt),
        .state  (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0]    yq;
        logic [3:0]    code;
        logic          ill;
        logic          alm;
        logic [CW-1:0] evt;
        logic [1:0]    st;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [8:0] legal_tbl [9] = '{9'h000, 9'h0C0, 9'h010, 9'h114, 9'h003,
                                  9'h00C, 9'h008, 9'h005, 9'h030};

    // Model state
    int m_st  = 0;
    int m_sil = 0;
    int m_evt = 0;
    exp_t m_out = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic int classify(input logic [8:0] v);
        for (int i = 0; i < 9; i++) begin
            if (legal_tbl[i] == v) return i;
        end
        return 15;
    endfunction

    task automatic model(input logic r, input logic e, input logic c, input logic [8:0] y);
        int cd;
        cd = classify(y);
        if (!r) begin
            m_st = 0; m_sil = 0; m_evt = 0;
            m_out = '0;
        end else begin
            m_out.yq   = y;
            m_out.code = 4'(cd);
            m_out.ill  = 1'b0;
            if (c) begin
                m_st = 0; m_sil = 0; m_evt = 0;
            end else if (m_st == 0) begin
                if (e) m_st = 1;
            end else if (m_st == 1) begin
                if (cd == 15) begin
                    m_out.ill = 1'b1;
                    m_sil = 0;
                    m_st = 2;
                end else if (cd == 0) begin
                    m_sil = m_sil + 1;
                    if (m_sil == SMAX) m_st = 2;
                    else if (!e) m_st = 0;
                end else begin
                    m_sil = 0;
                    if (m_evt < (1 << CW) - 1) m_evt = m_evt + 1;
                    if (!e) m_st = 0;
                end
            end
            m_out.st  = 2'(m_st);
            m_out.alm = (m_st == 2);
            m_out.evt = CW'(m_evt);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic c, input logic [8:0] y);
        exp_t ex;
        @(negedge clk);
        rst = r; en = e; clr = c; y_in = y;
        model(r, e, c, y);
        exp_q.push_back(m_out);
        @(posedge clk);
        #1;
        ex = exp_q.pop_front();
        check_eq("y_q",     32'(y_q),     32'(ex.yq));
        check_eq("code_id", 32'(code_id), 32'(ex.code));
        check_eq("illegal", 32'(illegal), 32'(ex.ill));
        check_eq("alarm",   32'(alarm),   32'(ex.alm));
        check_eq("evt_cnt", 32'(evt_cnt), 32'(ex.evt));
        check_eq("state",   32'(state),   32'(ex.st));
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; clr = 1'b0; y_in = '0;
        step(1'b0, 1'b1, 1'b1, 9'h1FF);
        step(1'b0, 1'b0, 1'b0, 9'h0C0);
        check_eq("reset_state", 32'(state), 32'd0);
        check_eq("reset_yq", 32'(y_q), 32'd0);

        // Decode sweep
        step(1'b1, 1'b1, 1'b0, 9'h000);
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b1, 1'b0, legal_tbl[i]);
            check_eq("sweep_code", 32'(code_id), 32'(i));
        end
        check_eq("sweep_evt", 32'(evt_cnt), 32'd8);
        check_eq("sweep_alarm", 32'(alarm), 32'd0);

        // Illegal code, then en low keeps ALARM, illegal in ALARM stays 0
        step(1'b1, 1'b1, 1'b0, 9'h1FF);
        check_eq("ill_pulse", 32'(illegal), 32'd1);
        check_eq("ill_state", 32'(state), 32'd2);
        step(1'b1, 1'b0, 1'b0, 9'h1FF);
        check_eq("ill_once", 32'(illegal), 32'd0);
        check_eq("alarm_hold", 32'(state), 32'd2);

        // Clear priority over illegal sample
        step(1'b1, 1'b1, 1'b1, 9'h1FF);
        check_eq("clr_state", 32'(state), 32'd0);
        check_eq("clr_evt", 32'(evt_cnt), 32'd0);

        // Silent: 7 zeros, a nonzero, 7 zeros (no alarm), then 8th zero
        step(1'b1, 1'b1, 1'b0, 9'h000);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 9'h000);
        step(1'b1, 1'b1, 1'b0, 9'h010);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 9'h000);
        check_eq("silent7", 32'(alarm), 32'd0);
        step(1'b1, 1'b1, 1'b0, 9'h000);
        check_eq("silent8", 32'(alarm), 32'd1);
        check_eq("silent_no_ill", 32'(illegal), 32'd0);
        step(1'b1, 1'b0, 1'b1, 9'h000);

        // Saturation
        step(1'b1, 1'b1, 1'b0, 9'h030);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, legal_tbl[1 + (i % 8)]);
        check_eq("sat_evt", 32'(evt_cnt), 32'hF);

        // Back to IDLE; illegal ignored there; en falling with illegal still alarms
        step(1'b1, 1'b0, 1'b0, 9'h003);
        step(1'b1, 1'b0, 1'b0, 9'h1FF);
        check_eq("idle_ignore", 32'(state), 32'd0);
        step(1'b1, 1'b1, 1'b0, 9'h000);
        step(1'b1, 1'b0, 1'b0, 9'h0FF);
        check_eq("enfall_alarm", 32'(state), 32'd2);

        // Reset mid-operation: evt=5 and alarm
        step(1'b1, 1'b0, 1'b1, 9'h000);
        step(1'b1, 1'b1, 1'b0, 9'h000);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 9'h005);
        step(1'b1, 1'b1, 1'b0, 9'h1FE);
        check_eq("pre_rst_evt", 32'(evt_cnt), 32'd5);
        step(1'b0, 1'b1, 1'b1, 9'h1FE);
        check_eq("rst_evt", 32'(evt_cnt), 32'd0);
        check_eq("rst_alarm", 32'(alarm), 32'd0);
        step(1'b1, 1'b1, 1'b0, 9'h010);
        check_eq("rst_run", 32'(state), 32'd1);

        // Random traffic, mostly legal codes
        for (int i = 0; i < 300; i++) begin
            logic [8:0] y;
            logic e, c, r;
            y = ($urandom_range(0, 9) == 0) ? 9'($urandom) : legal_tbl[$urandom_range(0, 8)];
            e = ($urandom_range(0, 7) != 0);
            c = ($urandom_range(0, 15) == 0);
            r = ($urandom_range(0, 40) != 0);
            step(r, e, c, y);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/girl10_out_mon.md
GIRL10_OUT_MON -- requirements
Module: girl10_out_mon

Interface
REQ-001 Parameter SILENT_MAX, default 8: number of consecutive all-zero samples that raises the silent alarm; legal range 2..255.
REQ-002 Parameter CNT_W, default 16: width of the event counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 en  input  1  monitoring enable.
REQ-006 clr  input  1  synchronous clear of alarm, counters and FSM.
REQ-007 y_in  input  9  FSM output vector from the upstream controller: bit0=y1, bit1=y2, bit2=y3, bit3=y4, bit4=y6, bit5=y7, bit6=y8, bit7=y9, bit8=y10.
REQ-008 y_q  output  9  y_in registered once.
REQ-009 code_id  output  4  registered classification of the sampled y_in.
REQ-010 illegal  output  1  one-cycle pulse: an illegal code was sampled while in RUN.
REQ-011 alarm  output  1  sticky alarm; high exactly while the FSM is in ALARM.
REQ-012 evt_cnt  output  CNT_W  saturating count of legal nonzero codes sampled in RUN.
REQ-013 state  output  2  FSM state: IDLE=0, RUN=1, ALARM=2.

Function
REQ-014 Every rising edge, y_q SHALL load y_in and code_id SHALL load the classification of y_in, in all states; latency is 1 cycle.
REQ-015 Classification SHALL be: 0x000->0; 0x0C0->1; 0x010->2; 0x114->3; 0x003->4; 0x00C->5; 0x008->6; 0x005->7; 0x030->8; any other value->15 (illegal).
REQ-016 IDLE->RUN when en=1; RUN->IDLE when en=0 and no alarm condition is present; RUN->ALARM on an illegal sample or when the silent condition is reached; ALARM->IDLE only when clr=1.
REQ-017 In ALARM, en SHALL have no effect; alarm SHALL stay 1; illegal SHALL stay 0; counters SHALL hold.
REQ-018 In RUN, the silent counter (8-bit) SHALL increment on code 0 and reset to 0 on any nonzero code.
REQ-019 The silent condition is reached on the edge that samples the SILENT_MAX-th consecutive zero; the FSM SHALL enter ALARM on that same edge.
REQ-020 In RUN, evt_cnt SHALL increment by 1 on codes 1..8 and SHALL saturate at all-ones without wrapping.
REQ-021 illegal SHALL be asserted the cycle after an illegal sample taken in RUN, for exactly one cycle, coincident with alarm rising.
REQ-022 In IDLE, the silent counter and evt_cnt SHALL hold, and illegal samples SHALL be ignored.
REQ-023 clr=1 SHALL force: state IDLE, alarm 0, illegal 0, evt_cnt 0, silent counter 0.
REQ-024 clr SHALL override en, illegal samples and the silent condition on the same edge.
REQ-025 An illegal sample and the silent condition cannot coincide; an illegal sample SHALL reset the silent counter.
REQ-026 en falling on the same edge as an illegal sample in RUN SHALL still produce ALARM: the alarm condition has priority over the return to IDLE.

Reset
REQ-027 rst=0 at a rising edge SHALL force: y_q 0, code_id 0, illegal 0, alarm 0, evt_cnt 0, silent counter 0, state IDLE.
REQ-028 Reset SHALL override clr and en.
REQ-029 Reset asserted mid-ALARM or mid-count SHALL take effect on the next edge with no residual state.

Verification
REQ-030 Decode sweep: apply en=1 and each of the nine legal codes once -> code_id equals 0..8 one cycle later; evt_cnt=8; alarm=0.
REQ-031 Illegal code: in RUN, y_in=0x1FF -> next cycle code_id=15, illegal=1 for one cycle, alarm=1, state=2; en=0 afterwards -> state stays 2.
REQ-032 Silent alarm: in RUN, y_in=0x000 for 7 cycles -> alarm=0; 8th zero sample -> alarm=1; with a 0x010 after 7 zeros -> no alarm, counter restarts.
REQ-033 Saturation: CNT_W=4, 20 legal nonzero samples in RUN -> evt_cnt=0xF and holds.
REQ-034 Clear priority: in ALARM, clr=1 together with y_in=0x1FF -> next cycle state=0, alarm=0, evt_cnt=0, illegal=0.
REQ-035 Reset mid-operation: evt_cnt=5, alarm=1, then rst=0 for one edge -> all outputs 0 and state=0; after rst=1 with en=1 -> state=1.
